// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (OR/AND/XOR/NOR) between two
// requesters, with latched operands and a single id-tagged registered response.
//
// state  | meaning
// IDLE   | waiting for a request; grant decided combinationally from the valids
// EXEC   | latched operands pass through the logic unit; result registered at the edge
// RESP   | response held on rsp_* until the consumer takes it
module logic_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic [CNT_W-1:0] r_ops_done;
    logic             w_gnt_id;
    logic             w_accept;
    logic             w_rsp_hs;
    logic [WIDTH-1:0] w_result;

    // On a tie the requester that did not win last time is granted.
    assign w_gnt_id = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept = req0_ready | req1_ready;
    assign w_rsp_hs = (r_state == S_RESP) & r_rsp_valid & rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0_valid | req1_valid) begin
                    req0_ready  = ~w_gnt_id;
                    req1_ready  = w_gnt_id;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (r_op)
            2'b00:   w_result = r_a | r_b;
            2'b01:   w_result = r_a & r_b;
            2'b10:   w_result = r_a ^ r_b;
            default: w_result = ~(r_a | r_b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= 2'b00;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_ops_done   <= '0;
        end else begin
            if (w_accept) begin
                r_id         <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_op         <= w_gnt_id ? req1_op : req0_op;
                r_a          <= w_gnt_id ? req1_a  : req0_a;
                r_b          <= w_gnt_id ? req1_b  : req0_b;
            end
            if (r_state == S_EXEC) begin
                r_rsp_data  <= w_result;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            // rsp_data is left untouched on the handshake so it keeps its last value.
            if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_ops_done  <= r_ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a transaction-level model predicts grants and
// results, a separate monitor pops and compares every response the DUT presents.
module tb_logic_unit_arbiter;

    localparam int W     = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic          req0_valid = 1'b0;
    logic [1:0]    req0_op    = 2'b00;
    logic [W-1:0]  req0_a     = '0;
    logic [W-1:0]  req0_b     = '0;
    logic          req1_valid = 1'b0;
    logic [1:0]    req1_op    = 2'b00;
    logic [W-1:0]  req1_a     = '0;
    logic [W-1:0]  req1_b     = '0;
    logic          rsp_ready  = 1'b0;

    logic          req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [W-1:0]  rsp_data;
    logic [CW-1:0] ops_done;

    logic          c2_req0_ready, c2_req1_ready, c2_rsp_valid, c2_rsp_id, c2_busy;
    logic [W-1:0]  c2_rsp_data;
    logic [1:0]    c2_ops_done;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .ops_done(ops_done)
    );

    // Narrow-counter build sharing the same stimulus, used to watch ops_done wrap.
    logic_unit_arbiter #(.WIDTH(W), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(c2_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(c2_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(c2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(c2_rsp_id),
        .rsp_data(c2_rsp_data), .busy(c2_busy), .ops_done(c2_ops_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction model: is a transaction outstanding, who won last, how many completed.
    bit          model_busy = 1'b0;
    bit          last_g     = 1'b1;
    int unsigned model_cnt  = 0;
    int          wr_idx     = 0;
    int          rd_idx     = 0;
    int          cyc        = 0;
    bit          exp_id   [DEPTH];
    logic [W-1:0] exp_data[DEPTH];
    int          exp_cyc  [DEPTH];

    bit          acc_flag = 1'b0;
    bit          acc_id   = 1'b0;
    logic [W-1:0] acc_data = '0;
    int          acc_cyc  = 0;
    bit          hs_flag  = 1'b0;
    bit          e0, e1;
    int          h;

    function automatic logic [W-1:0] lu(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_busy = 1'b0;
            last_g     = 1'b1;
            model_cnt  = 0;
            wr_idx     = 0;
        end else begin
            cyc = cyc + 1;
            if (acc_flag) begin
                exp_id[wr_idx % DEPTH]   = acc_id;
                exp_data[wr_idx % DEPTH] = acc_data;
                exp_cyc[wr_idx % DEPTH]  = acc_cyc;
                wr_idx     = wr_idx + 1;
                model_busy = 1'b1;
                last_g     = acc_id;
            end
            if (hs_flag) begin
                model_busy = 1'b0;
                model_cnt  = model_cnt + 1;
            end
        end
    end

    // Request-side checker: grants, busy, completed count, reset values.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_flag = 1'b0;
            #1;
            chk("reset_rsp", {rsp_valid, rsp_id, busy}, 32'd0);
            chk("reset_data", rsp_data, 32'd0);
            chk("reset_ops_done", {14'd0, c2_ops_done, ops_done}, 32'd0);
        end else begin
            e0 = !model_busy && req0_valid && !(req1_valid && last_g == 1'b0);
            e1 = !model_busy && req1_valid && !(req0_valid && last_g == 1'b1);
            chk("ready", {req1_ready, req0_ready}, {e1, e0});
            chk("busy", busy, model_busy);
            chk("ops_done", ops_done, model_cnt[CW-1:0]);
            chk("ops_done_cnt2", c2_ops_done, model_cnt[1:0]);
            acc_flag = e0 | e1;
            acc_id   = e1;
            acc_data = e1 ? lu(req1_op, req1_a, req1_b) : lu(req0_op, req0_a, req0_b);
            acc_cyc  = cyc;
        end
    end

    // Response monitor: the head of the queue must appear two edges after its acceptance.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx  = 0;
            hs_flag = 1'b0;
        end else begin
            hs_flag = 1'b0;
            if (rd_idx == wr_idx) begin
                chk("rsp_valid_no_txn", rsp_valid, 32'd0);
            end else begin
                h = rd_idx % DEPTH;
                chk("rsp_valid_latency", rsp_valid, (cyc >= exp_cyc[h] + 2) ? 32'd1 : 32'd0);
                if (rsp_valid) begin
                    chk("rsp_id", rsp_id, exp_id[h]);
                    chk("rsp_data", rsp_data, exp_data[h]);
                    if (rsp_ready) begin
                        rd_idx  = rd_idx + 1;
                        hs_flag = 1'b1;
                    end
                end
            end
        end
    end

    task automatic drive(input bit v0, input logic [1:0] o0, input logic [W-1:0] a0,
                         input logic [W-1:0] b0, input bit v1, input logic [1:0] o1,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input bit rr);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
    endtask

    task automatic drive_rand(input bit v0, input bit v1, input bit rr);
        drive(v0, 2'($urandom), W'($urandom), W'($urandom),
              v1, 2'($urandom), W'($urandom), W'($urandom), rr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0, 1'b1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        drive(1'b1, 2'b00, 8'hA5, 8'h5A, 1'b0, 2'b00, '0, '0, 1'b1);
        idle(4);

        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'b00, '0, '0, 1'b1, 2'(k), 8'hF0, 8'h3C, 1'b1);
            idle(3);
        end

        for (int i = 0; i < 20; i++) drive_rand(1'b1, 1'b1, 1'b1);
        idle(3);

        drive_rand(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive_rand(1'b1, 1'b1, 1'b0);
        drive_rand(1'b0, 1'b0, 1'b1);
        idle(3);

        drive(1'b1, 2'b10, 8'h0F, 8'hFF, 1'b0, 2'b00, '0, '0, 1'b1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(2);
        drive(1'b1, 2'b01, 8'hCC, 8'hAA, 1'b1, 2'b00, 8'h11, 8'h22, 1'b1);
        idle(4);

        for (int i = 0; i < 600; i++)
            drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0));
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
